// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
//   Quiz scoreboard. A debounced push-button registers one answer per press.
//   The exist input marks the answer correct or incorrect. A sequential
//   restoring divider works out the percentage of correct answers. Six
//   seven-segment digits show counts, percentage or total, as chosen by
//   display_state.
//
// Parameters
//   CNT_DIGITS     : decimal digits per score field (1..3)
//   DEBOUNCE_CYC   : stable synchronised samples needed for a level change
//   SEG_ACTIVE_LOW : 1 = a segment is lit by driving 0
//
// Ports
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   input_key     in   raw button, pressed = 0, asynchronous to clk
//   exist         in   1 = correct answer, sampled when a press is accepted
//   display_state in   0 counts, 1 percent, 2 total, 3 blank
//   hex5..hex0    out  segment patterns {g,f,e,d,c,b,a}, hex5 leftmost
//   busy          out  high while a percentage computation runs
//
// The divider state is held in state_q (S_IDLE/S_LOAD/S_DIV/S_DONE).
// ---------------------------------------------------------------------------
module score_display #(
  parameter int CNT_DIGITS     = 2,
  parameter int DEBOUNCE_CYC   = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       input_key,
  input  logic       exist,
  input  logic [1:0] display_state,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       busy
);

  localparam int MAX_COUNT = (CNT_DIGITS <= 1) ? 9 : (CNT_DIGITS == 2) ? 99 : 999;
  localparam int CW  = $clog2(MAX_COUNT + 1);
  localparam int TW  = $clog2(2 * MAX_COUNT + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYC);
  // 999 * 100 = 99900 fits in 17 bits, hence 17 quotient iterations.
  localparam int NW  = 17;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_COUNT);
  localparam logic [41:0]    DISP_OFF = (SEG_ACTIVE_LOW != 0) ? {42{1'b1}} : 42'd0;
  localparam logic [6:0]     SEG_P    = 7'h73;
  localparam logic [6:0]     SEG_T    = 7'h78;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} div_state_t;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic             armed_q, armed_d;
  logic             accept;
  logic [CW-1:0]    correct_q, correct_d, incorrect_q, incorrect_d;
  logic [TW-1:0]    total;
  div_state_t       state_q, state_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic [NW-1:0]    num_q, num_d;
  logic [TW-1:0]    rem_q, rem_d;
  logic [TW-1:0]    div_q, div_d;
  logic [TW:0]      rem_shift;
  logic [4:0]       iter_q, iter_d;
  logic [6:0]       percent_q, percent_d;
  logic [41:0]      disp_q, disp_d;
  logic [41:0]      raw;
  logic [9:0]       c10, i10, p10, t10;
  logic [10:0]      total_w;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Three right-aligned digits. Leading zeros are blank, and the units digit always shows.
  function automatic logic [20:0] num3(input logic [9:0] v);
    logic [3:0] h, t, u;
    h = 4'(v / 10'd100);
    t = 4'((v / 10'd10) % 10'd10);
    u = 4'(v % 10'd10);
    return {(v >= 10'd100) ? seg_of(h) : 7'h00,
            (v >= 10'd10)  ? seg_of(t) : 7'h00,
            seg_of(u)};
  endfunction

  assign total  = TW'(correct_q) + TW'(incorrect_q);
  // One event per press: the debounced level falling.
  assign accept = deb_prev_q & ~deb_q;
  assign rem_shift = {rem_q, num_q[NW-1]};

  always_comb begin
    sync1_d    = input_key;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    armed_d    = armed_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    // After reset the key must be seen released before any press counts.
    // This stops a key held across reset from registering.
    if (!armed_q) begin
      if (sync2_q) begin
        if (db_cnt_q == DB_LAST) armed_d = 1'b1;
        else                     db_cnt_d = db_cnt_q + DBW'(1);
      end
    end else if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) deb_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + DBW'(1);
    end

    correct_d   = correct_q;
    incorrect_d = incorrect_q;
    if (accept) begin
      if (exist && (correct_q != CNT_MAX))    correct_d   = correct_q + CW'(1);
      if (!exist && (incorrect_q != CNT_MAX)) incorrect_d = incorrect_q + CW'(1);
    end

    state_d   = state_q;
    pending_d = pending_q;
    num_d     = num_q;
    rem_d     = rem_q;
    div_d     = div_q;
    iter_d    = iter_q;
    percent_d = percent_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        num_d   = NW'(correct_q) * NW'(100);
        div_d   = total;
        rem_d   = '0;
        iter_d  = '0;
        state_d = S_DIV;
        // Counters change on this edge, after the operands were latched.
        if (accept) pending_d = 1'b1;
      end
      S_DIV: begin
        if (rem_shift >= {1'b0, div_q}) begin
          rem_d = TW'(rem_shift - {1'b0, div_q});
          num_d = {num_q[NW-2:0], 1'b1};
        end else begin
          rem_d = TW'(rem_shift);
          num_d = {num_q[NW-2:0], 1'b0};
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(NW - 1)) state_d = S_DONE;
        if (accept) pending_d = 1'b1;
      end
      S_DONE: begin
        // A stale result is dropped so that only the latest counts are shown.
        if (pending_q || accept) begin
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          percent_d = (div_q == '0) ? 7'd0 : num_q[6:0];
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);

    c10     = 10'(correct_q);
    i10     = 10'(incorrect_q);
    p10     = 10'(percent_q);
    total_w = 11'(total);
    t10     = (total_w > 11'd999) ? 10'd999 : total_w[9:0];
    case (display_state)
      2'd0:    raw = {num3(c10), num3(i10)};
      2'd1:    raw = {SEG_P, 14'd0, num3(p10)};
      2'd2:    raw = {SEG_T, 14'd0, num3(t10)};
      default: raw = 42'd0;
    endcase
    disp_d = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      deb_q       <= 1'b1;
      deb_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
      correct_q   <= '0;
      incorrect_q <= '0;
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      num_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      iter_q      <= '0;
      percent_q   <= '0;
      disp_q      <= DISP_OFF;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      armed_q     <= armed_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      iter_q      <= iter_d;
      percent_q   <= percent_d;
      disp_q      <= disp_d;
    end
  end

  assign hex5 = disp_q[41:35];
  assign hex4 = disp_q[34:28];
  assign hex3 = disp_q[27:21];
  assign hex2 = disp_q[20:14];
  assign hex1 = disp_q[13:7];
  assign hex0 = disp_q[6:0];
  assign busy = busy_q;

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter CNT_DIGITS, default 2, decimal digits per score field (legal 1..3); MAX_COUNT = 10^CNT_DIGITS-1.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 16, clk cycles input_key must be stable before a level change is accepted (legal >=2).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = segment lit by 0.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 input_key  input  1  raw push-button, active-low (pressed = 0), asynchronous to clk.
REQ-007 exist  input  1  sampled on the cycle a press is accepted; 1 = correct answer, 0 = incorrect.
REQ-008 display_state  input  2  display mode select, see REQ-020..023.
REQ-009 hex5..hex0  output  7 each  seven-segment patterns {g,f,e,d,c,b,a}; hex5 leftmost.
REQ-010 busy  output  1  high while percentage computation is in progress.

Function
REQ-011 input_key SHALL pass a 2-FF synchroniser, then a debounce counter; the debounced level changes only after DEBOUNCE_CYC consecutive equal synchronised samples.
REQ-012 A press SHALL be accepted on the cycle the debounced level goes 1->0; exactly one event per press, none on release.
REQ-013 On an accepted press with exist=1, correct SHALL increment; with exist=0, incorrect SHALL increment; each counter saturates at MAX_COUNT (no wrap).
REQ-014 total SHALL be correct+incorrect, held in a width sufficient for 2*MAX_COUNT.
REQ-015 percent SHALL be floor(correct*100/total), range 0..100; percent = 0 when total = 0.
REQ-016 percent SHALL be computed by a sequential restoring divider, one quotient bit per cycle; no combinational divider or modulo by a non-constant SHALL be used.
REQ-017 Divider FSM states: IDLE -> LOAD (latch numerator correct*100, divisor total) -> DIV (17 iterations) -> DONE (write percent) -> IDLE; busy high in LOAD, DIV, DONE.
REQ-018 percent SHALL reflect an accepted press exactly 20 cycles after the acceptance cycle; counters update 1 cycle after acceptance.
REQ-019 A press accepted while busy SHALL update counters immediately and set a pending flag; on DONE with pending set, FSM SHALL go to LOAD (not IDLE) and clear pending; multiple presses while busy collapse into one recompute using latest counts.
REQ-020 display_state=0: correct right-aligned in hex5..hex3, incorrect right-aligned in hex2..hex0.
REQ-021 display_state=1: hex5 shows 'P', hex4..hex3 blank, percent right-aligned in hex2..hex0.
REQ-022 display_state=2: hex5 shows 't', hex4..hex3 blank, total right-aligned in hex2..hex0, values >999 shown as 999.
REQ-023 display_state=3: all six digits blank.
REQ-024 Leading zeros SHALL be blanked; the units digit of every displayed number always shows (0 displays as '0').
REQ-025 hex outputs SHALL be registered, reflecting display_state and values of the previous cycle (1-cycle latency); percent shown is the last completed result, never a partial quotient.
REQ-026 Segment polarity SHALL follow SEG_ACTIVE_LOW; blank = all segments off.

Reset
REQ-027 resetn low SHALL immediately clear correct, incorrect, percent, pending, debounce state (debounced level = 1, released) and force FSM to IDLE, busy = 0.
REQ-028 During reset hex outputs SHALL be all-off (blank); after release, display follows REQ-020..023 from the first clk edge.
REQ-029 Reset asserted mid-division SHALL abort it; no stale percent written after release.
REQ-030 A key held low across reset release SHALL NOT generate a press until released and pressed again.

Verification
REQ-031 Reset, mode 0, no presses -> hex5..hex0 = blank,blank,'0',blank,blank,'0'; mode 1 -> 'P',blank,blank,blank,blank,'0'.
REQ-032 Press 3x exist=1, 1x exist=0 (each held 40 cycles) -> mode 0 shows '3' and '1'; 20 cycles after last acceptance mode 1 shows '75'; mode 2 shows 't' ... '4'.
REQ-033 Key bounce: 5 toggles of 3 cycles then stable low 40 cycles -> exactly one count increment.
REQ-034 Two presses accepted 5 cycles apart -> busy stays high continuously, single final percent = value for both presses, no intermediate overwrite after second.
REQ-035 101 presses exist=1 with CNT_DIGITS=2 -> correct saturates at 99, percent 100, no wrap to 0.
REQ-036 resetn pulsed low 8 cycles into a division -> busy drops asynchronously, all counts and percent 0, display blank during reset.
